// File: rtl/dppm_tx.sv
// Differential PPM transmitter: a reference pulse, then per symbol a gap of SLOT_BASE+v*SLOT_STEP clocks and a pulse.
// Latency: reference pulse starts the cycle after acceptance; frame = (NSYM+1)*PULSE_WIDTH + sum(gaps) + 1 cycles.
// Backpressure: data_ready is high only in IDLE/DONE; data_valid while not ready is dropped, never queued.
module dppm_tx #(
  parameter int PACKET_SIZE  = 32,
  parameter int SYMBOL_BITS  = 1,
  parameter int COUNTER_SIZE = 16,
  parameter int SLOT_BASE    = 4,
  parameter int SLOT_STEP    = 4,
  parameter int PULSE_WIDTH  = 1,
  parameter int LED_ACTIVE   = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PACKET_SIZE-1:0] data,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic                   led,
  output logic                   busy,
  output logic                   done
);

  localparam int     NSYM    = PACKET_SIZE / SYMBOL_BITS;
  localparam int     SYM_W   = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic   LED_ON  = (LED_ACTIVE != 0);
  localparam logic   LED_OFF = (LED_ACTIVE == 0);
  localparam longint CNT_MAX = (longint'(1) << COUNTER_SIZE) - 1;
  localparam longint GAP_MAX = longint'(SLOT_BASE)
                             + longint'((1 << SYMBOL_BITS) - 1) * longint'(SLOT_STEP);

  // Counter loads hold "cycles remaining minus one"; a state ends when the count reaches zero.
  localparam logic [COUNTER_SIZE-1:0] PULSE_LOAD = COUNTER_SIZE'(PULSE_WIDTH - 1);
  localparam logic [SYM_W-1:0]        LAST_SYM   = SYM_W'(NSYM - 1);

  // Reject parameter sets the counter or symbol slicing cannot represent.
  if (SYMBOL_BITS != 1 && SYMBOL_BITS != 2) begin : g_bad_symbol_bits
    $error("dppm_tx: SYMBOL_BITS must be 1 or 2");
  end
  if (PACKET_SIZE < SYMBOL_BITS || (PACKET_SIZE % SYMBOL_BITS) != 0) begin : g_bad_packet_size
    $error("dppm_tx: PACKET_SIZE must be a non-zero multiple of SYMBOL_BITS");
  end
  if (SLOT_BASE < 1) begin : g_bad_slot_base
    $error("dppm_tx: SLOT_BASE must be at least 1");
  end
  if (PULSE_WIDTH < 1) begin : g_bad_pulse_min
    $error("dppm_tx: PULSE_WIDTH must be at least 1");
  end
  if (longint'(PULSE_WIDTH) > CNT_MAX) begin : g_bad_pulse_max
    $error("dppm_tx: PULSE_WIDTH does not fit the interval counter");
  end
  if (GAP_MAX > CNT_MAX) begin : g_bad_gap_max
    $error("dppm_tx: longest gap does not fit the interval counter");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_GAP   = 3'd2,
    S_PULSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [COUNTER_SIZE-1:0] cnt_q, cnt_d;
  logic [PACKET_SIZE-1:0]  sr_q, sr_d;
  logic [SYM_W-1:0]        sym_q, sym_d;
  logic                    led_q, led_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ready_q, ready_d;
  logic                    accept;

  // Symbol currently at the transmit end of the shift register.
  function automatic logic [SYMBOL_BITS-1:0] cur_sym(input logic [PACKET_SIZE-1:0] sr);
    if (MSB_FIRST != 0) return sr[PACKET_SIZE-1 -: SYMBOL_BITS];
    else                return sr[SYMBOL_BITS-1:0];
  endfunction

  // Shift register after consuming one symbol.
  function automatic logic [PACKET_SIZE-1:0] next_sr(input logic [PACKET_SIZE-1:0] sr);
    if (MSB_FIRST != 0) return sr << SYMBOL_BITS;
    else                return sr >> SYMBOL_BITS;
  endfunction

  // Counter load for a gap carrying symbol value v.
  function automatic logic [COUNTER_SIZE-1:0] gap_load(input logic [SYMBOL_BITS-1:0] v);
    return COUNTER_SIZE'(SLOT_BASE - 1) + COUNTER_SIZE'(v) * COUNTER_SIZE'(SLOT_STEP);
  endfunction

  // Next-state, counter reload and symbol sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    sym_d   = sym_q;
    accept  = data_valid && ready_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = S_START;
          sr_d    = data;
          sym_d   = '0;
          cnt_d   = PULSE_LOAD;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = gap_load(cur_sym(sr_q));
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = PULSE_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          if (sym_q == LAST_SYM) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = S_GAP;
            sym_d   = sym_q + 1'b1;
            sr_d    = next_sr(sr_q);
            cnt_d   = gap_load(cur_sym(next_sr(sr_q)));
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    led_d   = (state_d == S_START || state_d == S_PULSE) ? LED_ON : LED_OFF;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE || state_d == S_DONE);
  end

  // State and registered outputs; reset drops any frame in flight with no done pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      sym_q   <= '0;
      led_q   <= LED_OFF;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      sym_q   <= sym_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign data_ready = ready_q;
  assign led        = led_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
